// File: rtl/fmul_arbiter.sv
// Two-requester round-robin arbiter in front of a single shared multiplier.
// One operation is in flight at a time; results are kept per requester.
module fmul_arbiter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         order0,
    output logic         accepted0,
    output logic         done0,
    input  logic [W-1:0] rs1_0,
    input  logic [W-1:0] rs2_0,
    output logic [W-1:0] rd0,
    input  logic         order1,
    output logic         accepted1,
    output logic         done1,
    input  logic [W-1:0] rs1_1,
    input  logic [W-1:0] rs2_1,
    output logic [W-1:0] rd1,
    output logic         u_order,
    input  logic         u_accepted,
    input  logic         u_done,
    output logic [W-1:0] u_rs1,
    output logic [W-1:0] u_rs2,
    input  logic [W-1:0] u_rd
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t        state;
    state_t        state_next;
    logic          ptr;
    logic          gnt;
    logic          grant_valid;
    logic          grant_idx;
    logic          capture;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic [W-1:0]  res0;
    logic [W-1:0]  res1;
    logic          done0_q;
    logic          done1_q;
    logic          u_order_q;

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, arbitration and same-cycle acceptance
    always_comb begin
        state_next  = state;
        grant_valid = 1'b0;
        grant_idx   = ptr;
        accepted0   = 1'b0;
        accepted1   = 1'b0;
        capture     = 1'b0;
        unique case (state)
            IDLE: begin
                if (order0 && order1) begin
                    grant_valid = 1'b1;
                    grant_idx   = ptr;
                end else if (order0) begin
                    grant_valid = 1'b1;
                    grant_idx   = 1'b0;
                end else if (order1) begin
                    grant_valid = 1'b1;
                    grant_idx   = 1'b1;
                end
                if (grant_valid) begin
                    state_next = ISSUE;
                    accepted0  = ~grant_idx;
                    accepted1  = grant_idx;
                end
            end
            ISSUE: begin
                if (u_accepted) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (u_done) begin
                    capture    = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Grant bookkeeping and operand capture
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr  <= 1'b0;
            gnt  <= 1'b0;
            op_a <= '0;
            op_b <= '0;
        end else if (grant_valid) begin
            ptr  <= ~grant_idx;
            gnt  <= grant_idx;
            op_a <= grant_idx ? rs1_1 : rs1_0;
            op_b <= grant_idx ? rs2_1 : rs2_0;
        end
    end

    // Per-requester results; done pulses land in the RESP cycle
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            res0    <= '0;
            res1    <= '0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
        end else begin
            done0_q <= capture & ~gnt;
            done1_q <= capture & gnt;
            if (capture && !gnt) begin
                res0 <= u_rd;
            end
            if (capture && gnt) begin
                res1 <= u_rd;
            end
        end
    end

    // Request to the multiplier is high exactly while in ISSUE
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            u_order_q <= 1'b0;
        end else begin
            u_order_q <= (state_next == ISSUE);
        end
    end

    assign done0   = done0_q;
    assign done1   = done1_q;
    assign rd0     = res0;
    assign rd1     = res1;
    assign u_order = u_order_q;
    assign u_rs1   = op_a;
    assign u_rs2   = op_b;

endmodule

// File: doc/fmul_arbiter.md
FMUL_ARBITER -- requirements
Module: fmul_arbiter

Interface
REQ-001 SHALL have parameter W, default 32, meaning operand and result width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port order0  input  1  requester 0 operation request, held until accepted0.
REQ-005 SHALL have port accepted0  output  1  requester 0 request taken this cycle.
REQ-006 SHALL have port done0  output  1  requester 0 result valid, one-cycle pulse.
REQ-007 SHALL have ports rs1_0, rs2_0  input  W  requester 0 operands; rd0  output  W  requester 0 result.
REQ-008 SHALL have ports order1, accepted1, done1, rs1_1, rs2_1, rd1 with the same directions, widths and meanings for requester 1.
REQ-009 SHALL have port u_order  output  1  request to the shared multiplier.
REQ-010 SHALL have port u_accepted  input  1  multiplier took the request.
REQ-011 SHALL have port u_done  input  1  multiplier result valid, one-cycle pulse.
REQ-012 SHALL have ports u_rs1, u_rs2  output  W  multiplier operands; u_rd  input  W  multiplier result.

Function
REQ-013 SHALL implement states IDLE, ISSUE, WAIT, RESP, plus a 1-bit round-robin pointer ptr and a 1-bit grant register gnt.
REQ-014 IDLE, single requester k with order_k=1: accepted_k=1 combinationally in the same cycle; latch rs1_k/rs2_k into operand registers; gnt<=k; next state ISSUE.
REQ-015 IDLE, both orders high: grant requester ptr; the other requester sees accepted=0 and keeps holding its request.
REQ-016 On every grant, ptr SHALL be set to the non-granted requester index (ptr <= ~k).
REQ-017 Outside IDLE, accepted0 and accepted1 SHALL be 0 regardless of the order inputs.
REQ-018 ISSUE: u_order=1, u_rs1/u_rs2 driven from the operand registers; on u_accepted=1, next state WAIT.
REQ-019 ISSUE: with u_accepted=0, stay in ISSUE with u_order and the operands held stable.
REQ-020 u_order SHALL be 0 in every state other than ISSUE.
REQ-021 WAIT: on u_done=1, capture u_rd into result register res_gnt; next state RESP.
REQ-022 RESP: done_gnt=1 for exactly one cycle, the other done=0; next state IDLE.
REQ-023 rd_k SHALL equal result register res_k, which holds its value until the next completion for requester k.
REQ-024 u_done while not in WAIT SHALL be ignored: no state, result or done change.
REQ-025 Latency SHALL be: acceptance at cycle T, u_order from T+1, done_k one cycle after the u_done cycle; a new acceptance is possible no earlier than the cycle after RESP.
REQ-026 Throughput SHALL be one operation in flight; no second grant before RESP completes.
REQ-027 An order dropped before acceptance SHALL be discarded with no side effects.
REQ-028 The arbiter SHALL NOT inspect or modify operand or result data; the result is bit-exact u_rd.

Reset
REQ-029 rstn=0 SHALL asynchronously force: state=IDLE, ptr=0, gnt=0, operand registers=0, res0=res1=0.
REQ-030 During and right after reset: u_order=0, done0=done1=0, rd0=rd1=0; accepted_k then follows REQ-014/015 from the first cycle after release.
REQ-031 Reset mid-operation, in any state, SHALL abandon the in-flight operation: no done pulse for it, and any later u_done is ignored per REQ-024.

Verification
REQ-032 Single op: order0=1, rs1_0=0x40000000, rs2_0=0x40400000 -> accepted0 same cycle, u_order next cycle, done0 one cycle after u_done, rd0=0x40C00000, done1 stays 0.
REQ-033 Simultaneous orders after reset (ptr=0): req0 0x3FC00000*0x40000000, req1 0xBF800000*0x40800000 -> req0 served first with rd0=0x40400000, then req1 with rd1=0xC0800000, no overlap on u_order.
REQ-034 Fairness: both orders held continuously for 6 operations -> grants alternate 0,1,0,1,0,1.
REQ-035 Backpressure: u_accepted held 0 for 5 cycles in ISSUE -> u_order and u_rs1/u_rs2 stable; accepted0/1=0 throughout.
REQ-036 Reset in WAIT: rstn pulsed low, then a stray u_done -> no done pulse, rd0=rd1=0, state IDLE.
REQ-037 Spurious u_done in IDLE with order0=order1=0 -> no done pulse, rd0/rd1 unchanged.
